// File: rtl/instruction_sram_axi_bridge_if.sv
// Bus bundles for the instruction fetch bridge.
// instruction_sram_if : sram-like fetch port between the IF stage (master)
//                       and the bridge (slave).
// instruction_axi_rd_if : AXI4 AR/R channel pair between the bridge (master)
//                         and the interconnect (slave).

interface instruction_sram_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     instruction_ram_request;
    logic                     instruction_ram_write;
    logic [1:0]               instruction_ram_size;
    logic [ADDRESS_WIDTH-1:0] instruction_ram_address;
    logic                     instruction_ram_address_ready;
    logic                     instruction_ram_data_ready;
    logic [ADDRESS_WIDTH-1:0] instruction_ram_read_data;

    // IF stage view
    modport master (
        output instruction_ram_request,
        output instruction_ram_write,
        output instruction_ram_size,
        output instruction_ram_address,
        input  instruction_ram_address_ready,
        input  instruction_ram_data_ready,
        input  instruction_ram_read_data
    );

    // Bridge view
    modport slave (
        input  instruction_ram_request,
        input  instruction_ram_write,
        input  instruction_ram_size,
        input  instruction_ram_address,
        output instruction_ram_address_ready,
        output instruction_ram_data_ready,
        output instruction_ram_read_data
    );
endinterface

interface instruction_axi_rd_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic [3:0]               arid;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;
    logic [3:0]               rid;
    logic [ADDRESS_WIDTH-1:0] rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    // Bridge view
    modport master (
        output arid,
        output araddr,
        output arlen,
        output arsize,
        output arburst,
        output arvalid,
        input  arready,
        input  rid,
        input  rdata,
        input  rresp,
        input  rlast,
        input  rvalid,
        output rready
    );

    // Interconnect view
    modport slave (
        input  arid,
        input  araddr,
        input  arlen,
        input  arsize,
        input  arburst,
        input  arvalid,
        output arready,
        output rid,
        output rdata,
        output rresp,
        output rlast,
        output rvalid,
        input  rready
    );
endinterface

// File: rtl/instruction_sram_axi_bridge.sv
// Instruction fetch bridge: sram-like request/address_ready/data_ready port
// to AXI4 single-beat reads. Up to MAX_OUTSTANDING fetches in flight, data
// returned in order straight from the R channel with no buffering.

module instruction_sram_axi_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'h0,
    parameter int         ADDRESS_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_sram_if.slave    sram,
    instruction_axi_rd_if.master axi,
    output logic                 bus_error
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE = 1'b0,
        ADDR = 1'b1
    } ar_state_t;

    ar_state_t                state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] araddr_reg, araddr_next;
    logic [2:0]               arsize_reg, arsize_next;
    logic [CW-1:0]            count_reg, count_next;
    logic                     bus_error_reg, bus_error_next;

    logic accept;
    logic r_handshake;

    // rid and rlast carry nothing the bridge needs for single-beat in-order reads
    logic unused_axi_bits;
    assign unused_axi_bits = ^{axi.rid, axi.rlast};

    // Accept only from IDLE with room left; gated by reset so it reads 0 while held
    assign accept = reset
                 && (state_reg == IDLE)
                 && sram.instruction_ram_request
                 && !sram.instruction_ram_write
                 && (count_reg < MAX_CNT);

    assign r_handshake = axi.rvalid && axi.rready;

    assign sram.instruction_ram_address_ready = accept;
    assign sram.instruction_ram_data_ready    = r_handshake;
    assign sram.instruction_ram_read_data     = axi.rdata;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = araddr_reg;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = arsize_reg;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = (state_reg == ADDR);
    assign axi.rready  = (count_reg != '0);

    assign bus_error = bus_error_reg;

    // AR state machine: latch the request on accept, hold it until arready
    always_comb begin
        state_next  = state_reg;
        araddr_next = araddr_reg;
        arsize_next = arsize_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    araddr_next = sram.instruction_ram_address;
                    arsize_next = {1'b0, sram.instruction_ram_size};
                    state_next  = ADDR;
                end
            end
            ADDR: begin
                if (axi.arready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outstanding count: +1 on accept, -1 on R handshake, unchanged on both
    always_comb begin
        count_next = count_reg;
        case ({accept, r_handshake})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Sticky error: error response on a returned beat, or any write attempt
    always_comb begin
        bus_error_next = bus_error_reg;
        if (r_handshake && (axi.rresp != 2'b00)) begin
            bus_error_next = 1'b1;
        end
        if (sram.instruction_ram_request && sram.instruction_ram_write) begin
            bus_error_next = 1'b1;
        end
    end

    // State registers; reset drops every in-flight fetch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            araddr_reg    <= '0;
            arsize_reg    <= 3'b010;
            count_reg     <= '0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            araddr_reg    <= araddr_next;
            arsize_reg    <= arsize_next;
            count_reg     <= count_next;
            bus_error_reg <= bus_error_next;
        end
    end

endmodule
